// File: rtl/very_simple_cpu.sv
// Multi-cycle memory-to-memory CPU: every operand lives in RAM, one access per cycle.
// Define VSCPU_INTERRUPT_EN to build the single-level, non-nesting interrupt controller.
module very_simple_cpu #(
  parameter int ISR_VEC_ADDR = 20,
  parameter int RET_ADDR     = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt,
  input  logic [31:0] data_fromRAM,
  output logic        wrEn,
  output logic [13:0] addr_toRAM,
  output logic [31:0] data_toRAM
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_CP   = 3'd4;
  localparam logic [2:0] OP_CPI  = 3'd5;
  localparam logic [2:0] OP_BZJ  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

`ifdef VSCPU_INTERRUPT_EN
  typedef enum logic [2:0] {
    S_FETCH, S_LOADA, S_LOADB, S_INDIR, S_EXEC, S_INT_SAVE, S_INT_VEC, S_INT_JMP
  } state_t;

  localparam logic [13:0] RET_A = 14'(RET_ADDR);
  localparam logic [13:0] VEC_A = 14'(ISR_VEC_ADDR);

  logic pending_q, pending_d;
  logic in_isr_q, in_isr_d;
`else
  typedef enum logic [2:0] {
    S_FETCH, S_LOADA, S_LOADB, S_INDIR, S_EXEC
  } state_t;

  localparam int unused_params = ISR_VEC_ADDR + RET_ADDR;
  logic unused_interrupt;
  assign unused_interrupt = interrupt;
`endif

  state_t      state_q, state_d;
  logic [13:0] pc_q, pc_d;
  logic [31:0] iw_q, iw_d;
  logic [31:0] ra_q, ra_d;
  logic [31:0] rb_q, rb_d;

  logic [2:0]  opc;
  logic        imm;
  logic [13:0] a_fld;
  logic [13:0] b_fld;
  logic [31:0] opnd;
  logic [31:0] alu_res;

  assign opc   = iw_q[31:29];
  assign imm   = iw_q[28];
  assign a_fld = iw_q[27:14];
  assign b_fld = iw_q[13:0];
  // In EXEC the RAM returns m[B], addressed during LOADB.
  assign opnd  = imm ? {18'd0, b_fld} : data_fromRAM;

  always_comb begin
    alu_res = '0;
    case (opc)
      OP_ADD:  alu_res = ra_q + opnd;
      OP_NAND: alu_res = ~(ra_q & opnd);
      OP_SRL:  alu_res = (opnd < 32'd32) ? (ra_q >> opnd) : (ra_q << (opnd - 32'd32));
      OP_LT:   alu_res = {31'd0, (ra_q < opnd)};
      OP_CP:   alu_res = opnd;
      OP_MUL:  alu_res = ra_q * opnd;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iw_d       = iw_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    wrEn       = 1'b0;
    addr_toRAM = '0;
    data_toRAM = '0;
`ifdef VSCPU_INTERRUPT_EN
    pending_d  = pending_q | interrupt;
    in_isr_d   = in_isr_q;
`endif
    case (state_q)
      S_FETCH: begin
        addr_toRAM = pc_q;
        state_d    = S_LOADA;
      end
      S_LOADA: begin
        iw_d       = data_fromRAM;
        addr_toRAM = data_fromRAM[27:14];
        state_d    = S_LOADB;
      end
      S_LOADB: begin
        ra_d       = data_fromRAM;
        addr_toRAM = b_fld;
        state_d    = (opc == OP_CPI) ? S_INDIR : S_EXEC;
      end
      S_INDIR: begin
        // CPI follows the pointer just read from m[B]; CPIi parks on the target m[A].
        rb_d       = data_fromRAM;
        addr_toRAM = imm ? ra_q[13:0] : data_fromRAM[13:0];
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        pc_d    = pc_q + 14'd1;
        state_d = S_FETCH;
        if (!((opc == OP_CPI) && imm)) begin
          rb_d = data_fromRAM;
        end
        case (opc)
          OP_BZJ: begin
            if (imm) begin
              pc_d = ra_q[13:0] + b_fld;
            end else if (data_fromRAM == '0) begin
              pc_d = ra_q[13:0];
            end
`ifdef VSCPU_INTERRUPT_EN
            in_isr_d = 1'b0;
`endif
          end
          OP_CPI: begin
            wrEn = 1'b1;
            if (imm) begin
              addr_toRAM = ra_q[13:0];
              data_toRAM = rb_q;
            end else begin
              addr_toRAM = a_fld;
              data_toRAM = data_fromRAM;
            end
          end
          default: begin
            wrEn       = 1'b1;
            addr_toRAM = a_fld;
            data_toRAM = alu_res;
          end
        endcase
`ifdef VSCPU_INTERRUPT_EN
        // Only instruction boundaries are interruptible; a returning BZJ re-opens the gate.
        if (pending_q && !in_isr_d) begin
          state_d = S_INT_SAVE;
        end
`endif
      end
`ifdef VSCPU_INTERRUPT_EN
      S_INT_SAVE: begin
        wrEn       = 1'b1;
        addr_toRAM = RET_A;
        data_toRAM = {18'd0, pc_q};
        state_d    = S_INT_VEC;
      end
      S_INT_VEC: begin
        addr_toRAM = VEC_A;
        state_d    = S_INT_JMP;
      end
      S_INT_JMP: begin
        pc_d      = data_fromRAM[13:0];
        in_isr_d  = 1'b1;
        pending_d = interrupt;
        state_d   = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      iw_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
`ifdef VSCPU_INTERRUPT_EN
      pending_q <= 1'b0;
      in_isr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      iw_q      <= iw_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
`ifdef VSCPU_INTERRUPT_EN
      pending_q <= pending_d;
      in_isr_q  <= in_isr_d;
`endif
    end
  end

endmodule

// File: tb/tb_very_simple_cpu.sv
// Bench for very_simple_cpu: directed programs plus random programs, each instruction
// checked against an instruction-level reference model of the CPU and its RAM.
module tb_very_simple_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt;
  logic [31:0] data_fromRAM;
  logic        wrEn;
  logic [13:0] addr_toRAM;
  logic [31:0] data_toRAM;

  very_simple_cpu dut (
    .clk          (clk),
    .rst          (rst),
    .interrupt    (interrupt),
    .data_fromRAM (data_fromRAM),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] I_ADD  = 3'd0;
  localparam logic [2:0] I_NAND = 3'd1;
  localparam logic [2:0] I_LT   = 3'd3;
  localparam logic [2:0] I_CP   = 3'd4;
  localparam logic [2:0] I_BZJ  = 3'd6;

  // Synchronous RAM with one-cycle read latency; bench loads go through the same port.
  logic [31:0] ram [0:16383];
  logic        clr_en, ld_en;
  logic [13:0] ld_addr;
  logic [31:0] ld_data;

  always @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < 16384; i++) ram[i] <= '0;
    end else if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (wrEn) begin
      ram[addr_toRAM] <= data_toRAM;
    end
    data_fromRAM <= ram[addr_toRAM];
  end

  // Reference model: architectural memory and PC, stepped one whole instruction at a time.
  logic [31:0] mm [0:16383];
  logic [13:0] m_pc;
`ifdef VSCPU_INTERRUPT_EN
  bit m_pending, m_in_isr;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input bit im, input int a, input int b);
    return {op, im, 14'(a), 14'(b)};
  endfunction

  task automatic load(input int a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = 14'(a);
    ld_data = d;
    mm[a]   = d;
    @(posedge clk); #1;
    ld_en   = 1'b0;
  endtask

  task automatic model_step(output logic we, output logic [13:0] wa, output logic [31:0] wd,
                            output int cyc, output logic [13:0] npc, output bit is_bzj);
    logic [31:0] iw, va, vb, op;
    logic [2:0]  opc;
    logic        im;
    logic [13:0] a, b;
    iw  = mm[m_pc];
    opc = iw[31:29];
    im  = iw[28];
    a   = iw[27:14];
    b   = iw[13:0];
    va  = mm[a];
    vb  = mm[b];
    op  = im ? 32'(b) : vb;
    we = 1'b1; wa = a; wd = '0; cyc = 4; npc = m_pc + 14'd1; is_bzj = 1'b0;
    case (opc)
      3'd0: wd = va + op;
      3'd1: wd = ~(va & op);
      3'd2: wd = (op < 32) ? (va >> op) : (va << (op - 32));
      3'd3: wd = (va < op) ? 32'd1 : 32'd0;
      3'd4: wd = op;
      3'd5: begin
        cyc = 5;
        if (im) begin
          wa = va[13:0];
          wd = vb;
        end else begin
          wd = mm[vb[13:0]];
        end
      end
      3'd6: begin
        we = 1'b0;
        is_bzj = 1'b1;
        if (im) npc = va[13:0] + b;
        else if (vb == 0) npc = va[13:0];
      end
      default: wd = va * op;
    endcase
  endtask

`ifdef VSCPU_INTERRUPT_EN
  task automatic service(input bit pulse_jmp);
    check("save_wren", 32'(wrEn), 32'd1);
    check("save_addr", 32'(addr_toRAM), 32'd21);
    check("save_data", data_toRAM, 32'(m_pc));
    mm[21] = 32'(m_pc);
    @(posedge clk); #1;
    check("vec_addr", 32'(addr_toRAM), 32'd20);
    check("vec_wren", 32'(wrEn), 32'd0);
    @(posedge clk); #1;
    interrupt = pulse_jmp;
    check("jmp_wren", 32'(wrEn), 32'd0);
    $display("irq saved_pc=%0d vector=%0d jmp_pulse=%0b", m_pc, mm[20][13:0], pulse_jmp);
    m_pc      = mm[20][13:0];
    m_in_isr  = 1'b1;
    m_pending = pulse_jmp;
    @(posedge clk); #1;
    interrupt = 1'b0;
  endtask
`endif

  // Entered #1 after the edge that starts FETCH; returns at the next FETCH.
  task automatic do_instr(input bit pulse, input bit pulse_jmp);
    logic        we;
    logic [13:0] wa, npc, pc0;
    logic [31:0] wd;
    int          cyc;
    bit          is_bzj;
    pc0 = m_pc;
    model_step(we, wa, wd, cyc, npc, is_bzj);
    check("fetch_addr", 32'(addr_toRAM), 32'(m_pc));
    check("fetch_wren", 32'(wrEn), 32'd0);
    for (int c = 1; c < cyc; c++) begin
      @(posedge clk); #1;
      interrupt = (c == 1) && pulse;
    end
    check("exec_wren", 32'(wrEn), 32'(we));
    if (we) begin
      check("exec_addr", 32'(addr_toRAM), 32'(wa));
      check("exec_data", data_toRAM, wd);
    end
    $display("instr pc=%0d iw=%h we=%0b addr=%0d data=%h bzj=%0b next=%0d",
             pc0, mm[pc0], we, wa, wd, is_bzj, npc);
    if (we) mm[wa] = wd;
    m_pc = npc;
    @(posedge clk); #1;
`ifdef VSCPU_INTERRUPT_EN
    if (is_bzj) m_in_isr = 1'b0;
    if (pulse) m_pending = 1'b1;
    if (m_pending && !m_in_isr) service(pulse_jmp);
`else
    if (pulse || pulse_jmp) $display("interrupt pulse ignored (controller not built)");
`endif
  endtask

  initial begin
    logic [2:0] r_op;
    bit         r_im;
    int         r_a, r_b;

    rst = 1'b1; interrupt = 1'b0; clr_en = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 16384; i++) mm[i] = '0;
    m_pc = '0;
`ifdef VSCPU_INTERRUPT_EN
    m_pending = 1'b0;
    m_in_isr  = 1'b0;
`endif
    @(posedge clk); #1;
    clr_en = 1'b0;

    load(0, enc(I_CP,   1'b0, 15, 16));
    load(1, enc(I_NAND, 1'b0, 15, 16));
    load(2, enc(I_ADD,  1'b1, 15, 1));
    load(3, enc(I_ADD,  1'b0, 17, 15));
    load(4, enc(I_CP,   1'b0, 12, 17));
    load(5, enc(I_LT,   1'b0, 12, 16));
    load(6, enc(I_BZJ,  1'b0, 40, 41));
    load(7, enc(I_ADD,  1'b1, 50, 3));
    load(8, enc(I_BZJ,  1'b1, 60, 100));
    load(16, 32'd5);
    load(17, 32'hB);
    load(40, 32'd90);
    load(41, 32'd7);
    load(20, 32'd30);
    load(30, enc(I_NAND, 1'b0, 10, 10));
    load(31, enc(I_ADD,  1'b1, 10, 1));
    load(32, enc(I_BZJ,  1'b0, 21, 300));

    for (int i = 0; i < 64; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_im = 1'($urandom_range(0, 1));
      r_a  = 200 + int'($urandom_range(0, 31));
      r_b  = r_im ? int'($urandom_range(0, 63)) : 200 + int'($urandom_range(0, 31));
      load(100 + i, enc(r_op, r_im, r_a, r_b));
    end
    for (int i = 0; i < 32; i++) begin
      load(200 + i, ($urandom_range(0, 1) == 1) ? 32'(100 + $urandom_range(0, 63)) : $urandom());
    end

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rst_wren", 32'(wrEn), 32'd0);
      check("rst_addr", 32'(addr_toRAM), 32'd0);
      check("rst_data", data_toRAM, 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_instr(1'b0, 1'b0);
    check("m15_nand_addi", ram[15], 32'hFFFF_FFFB);
    check("m17_add_wrap", ram[17], 32'h6);
    check("m12_lt_false", ram[12], 32'h0);
    check("m41_bzj_nowrite", ram[41], 32'h7);

    do_instr(1'b1, 1'b0);
    check("m50_once", ram[50], 32'd3);
`ifdef VSCPU_INTERRUPT_EN
    check("m21_saved_pc", ram[21], 32'd8);
    do_instr(1'b1, 1'b0);
    do_instr(1'b0, 1'b0);
    do_instr(1'b0, 1'b1);
    check("m10_isr_result", ram[10], 32'd0);
    for (int i = 0; i < 6; i++) do_instr(1'b0, 1'b0);
`endif
    do_instr(1'b0, 1'b0);
    check("bzji_target", 32'(addr_toRAM), 32'd100);

    for (int i = 0; i < 150; i++) begin
      do_instr($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset landing in the middle of an instruction.
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_wren", 32'(wrEn), 32'd0);
    check("midrst_addr", 32'(addr_toRAM), 32'd0);
    check("midrst_data", data_toRAM, 32'd0);
    rst = 1'b0;
    m_pc = '0;
`ifdef VSCPU_INTERRUPT_EN
    m_pending = 1'b0;
    m_in_isr  = 1'b0;
`endif
    for (int i = 0; i < 4; i++) do_instr(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
